// File: rtl/y86_pkg.sv
// y86_pkg: shared definitions for the Y86-64 data memory.
//   DATA_W       - machine word width
//   DEPTH        - default number of data-memory words
//   dmem_state_t - handshake FSM states of y86_dmem
package y86_pkg;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/y86_dmem_array.sv
// y86_dmem_array: word storage for y86_dmem. No reset; contents are
// undefined until written.
//   clk          - clock
//   we/waddr/wdata - synchronous write port
//   re/raddr     - synchronous read port, rdata updates only when re=1
//   rdata        - registered read data, holds between reads
module y86_dmem_array #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/y86_dmem.sv
// y86_dmem: registered request/response data memory for the Y86-64
// memory stage. One access in flight; WAIT_CYC extra cycles per access.
//   clk, rst_n                 - clock, async active-low reset
//   req_valid/req_ready        - request handshake (accept on valid&&ready)
//   req_we/req_addr/req_wdata  - store flag, word index, store data
//   rsp_valid                  - one-cycle response strobe
//   rsp_rdata/rsp_err          - load data / range error, held until the
//                                next response
module y86_dmem #(
  parameter int DATA_W   = y86_pkg::DATA_W,
  parameter int DEPTH    = y86_pkg::DEPTH,
  parameter int ADDR_W   = 64,
  parameter int WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  import y86_pkg::*;

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [3:0]        CNT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  dmem_state_t       state;
  logic [3:0]        cnt;

  // request captured at acceptance, used when the commit is deferred
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;

  logic              accept;
  logic              commit;
  logic              acc_we;
  logic              acc_err;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  logic              rsp_load_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] arr_rdata;

  assign req_ready = (state != WAIT);
  assign accept    = req_valid && req_ready;

  // The access commits on the edge that enters RESP. With no wait states
  // that is the accept edge itself, so the live request is used; otherwise
  // the captured copy is used on the final WAIT edge.
  always_comb begin
    acc_we    = req_we;
    acc_addr  = req_addr;
    acc_wdata = req_wdata;
    commit    = accept && (WAIT_CYC == 0);
    if (state == WAIT) begin
      acc_we    = cap_we;
      acc_addr  = cap_addr;
      acc_wdata = cap_wdata;
      commit    = (cnt == 4'd0);
    end
  end

  // full-width compare: high address bits must not alias into the array
  assign acc_err = (acc_addr >= DEPTH_A);

  y86_dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (commit && acc_we && !acc_err && rst_n),
    .waddr (acc_addr[IDX_W-1:0]),
    .wdata (acc_wdata),
    .re    (commit && !acc_we && !acc_err),
    .raddr (acc_addr[IDX_W-1:0]),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      cap_we     <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      rsp_load_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        cap_we    <= req_we;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
      end
      if (commit) begin
        rsp_load_q <= !acc_we && !acc_err;
        rsp_err_q  <= acc_err;
      end
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            if (WAIT_CYC == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_err_q;
  // the array read register holds between loads; stores/errors read as zero
  assign rsp_rdata = rsp_load_q ? arr_rdata : '0;

endmodule
